// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared IFU types: fetch address/instruction widths, reset PC and FSM state encodings.
// Also holds the redirect alignment helper used by the PC register.
package ysyx_23060332_ifu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  // Branch targets are forced to word alignment.
  function automatic addr_t align_target(input addr_t a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// IFU bus bundle: imem request/response, decode-stage handoff and execute-stage redirect.
// master = IFU side, slave = memory/pipeline environment side.
interface ysyx_23060332_ifu_if;
  import ysyx_23060332_ifu_pkg::*;

  logic  imem_req_valid;
  addr_t imem_req_addr;
  logic  imem_req_ready;
  logic  imem_rsp_valid;
  inst_t imem_rsp_data;
  logic  inst_valid;
  logic  inst_ready;
  inst_t inst_o;
  addr_t inst_addr;
  logic  redirect_en;
  addr_t redirect_addr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_o, inst_addr,
    input  inst_ready, redirect_en, redirect_addr
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_o, inst_addr,
    output inst_ready, redirect_en, redirect_addr
  );

endinterface

// File: rtl/ysyx_23060332_ifu_pc_reg.sv
// Program counter: hold, +4 on decode handshake, or aligned redirect target (redirect wins).
// pc_next is combinational so the FSM can load the request address in the same cycle.
module ysyx_23060332_pc_reg
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  advance,
  input  logic  redirect_en,
  input  addr_t redirect_addr,
  output addr_t pc_next
);

  addr_t pc;

  always_comb begin
    pc_next = pc;
    if (redirect_en)
      pc_next = align_target(redirect_addr);
    else if (advance)
      pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Non-pipelined fetch unit: REQ -> WAIT -> OUT, one outstanding request, responses killed by redirect.
// Latency rsp->inst_valid 1 cycle; backpressure holds request/instruction until the handshake.
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_23060332_ifu_if.master  bus
);

  ifu_state_e state;
  logic       kill;
  logic       req_valid;
  addr_t      req_addr;
  logic       inst_valid;
  inst_t      inst_o;
  addr_t      inst_addr;
  addr_t      pc_next;
  logic       advance;

  assign advance = (state == S_OUT) && inst_valid && bus.inst_ready;

  ysyx_23060332_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .advance       (advance),
    .redirect_en   (bus.redirect_en),
    .redirect_addr (bus.redirect_addr),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      kill       <= 1'b0;
      req_valid  <= 1'b0;
      req_addr   <= RESET_PC;
      inst_valid <= 1'b0;
      inst_o     <= '0;
      inst_addr  <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (!req_valid) begin
            // Nothing issued yet (post-reset): retarget freely, no kill needed.
            req_valid <= 1'b1;
            req_addr  <= pc_next;
          end else begin
            // An issued request is never withdrawn; a redirect only marks its response dead.
            if (bus.redirect_en)
              kill <= 1'b1;
            if (bus.imem_req_ready) begin
              req_valid <= 1'b0;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (kill || bus.redirect_en) begin
              kill      <= 1'b0;
              req_valid <= 1'b1;
              req_addr  <= pc_next;
              state     <= S_REQ;
            end else begin
              inst_o     <= bus.imem_rsp_data;
              inst_addr  <= req_addr;
              inst_valid <= 1'b1;
              state      <= S_OUT;
            end
          end else if (bus.redirect_en) begin
            kill <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.redirect_en || bus.inst_ready) begin
            inst_valid <= 1'b0;
            req_valid  <= 1'b1;
            req_addr   <= pc_next;
            state      <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_addr;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst_o         = inst_o;
  assign bus.inst_addr      = inst_addr;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for the fetch unit: inputs driven and outputs sampled on the falling edge.
// Memory and decode stage are played by hand, step by step.
module tb_ysyx_23060332_ifu;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ysyx_23060332_ifu_if bus ();

  ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic vld, input logic [31:0] addr);
    chk({tag, "_req_valid"}, {31'd0, bus.imem_req_valid}, {31'd0, vld});
    if (vld)
      chk({tag, "_req_addr"}, bus.imem_req_addr, addr);
  endtask

  task automatic chk_inst(input string tag, input logic vld, input logic [31:0] data,
                          input logic [31:0] addr);
    chk({tag, "_inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, vld});
    if (vld) begin
      chk({tag, "_inst_o"}, bus.inst_o, data);
      chk({tag, "_inst_addr"}, bus.inst_addr, addr);
    end
  endtask

  // Accept the pending request, then return one response word on the next cycle.
  task automatic fetch(input logic [31:0] data);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_en    = 1'b0;
    bus.redirect_addr  = 32'h0;

    tick(); tick();
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst_o", bus.inst_o, 32'h0);
    chk("rst_inst_addr", bus.inst_addr, 32'h0);

    rst = 1'b0;
    tick();
    chk_req("first", 1'b1, 32'h8000_0000);

    // Basic fetch of the reset word.
    fetch(32'h0000_0413);
    chk_req("basic_out", 1'b0, 32'h0);
    chk_inst("basic_out", 1'b1, 32'h0000_0413, 32'h8000_0000);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk_inst("basic_next", 1'b0, 32'h0, 32'h0);
    chk_req("basic_next", 1'b1, 32'h8000_0004);

    // Memory not ready for 3 cycles: request held.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req("req_stall", 1'b1, 32'h8000_0004);
    end
    fetch(32'h0010_0093);
    chk_inst("stall_out", 1'b1, 32'h0010_0093, 32'h8000_0004);

    // Decode not ready for 5 cycles: instruction held, no new request.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_inst("out_stall", 1'b1, 32'h0010_0093, 32'h8000_0004);
      chk_req("out_stall", 1'b0, 32'h0);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk_req("out_release", 1'b1, 32'h8000_0008);

    // Redirect while waiting for the response.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_en    = 1'b1;
    bus.redirect_addr  = 32'h8000_0103;
    tick();
    bus.redirect_en    = 1'b0;
    chk_inst("wait_redir_a", 1'b0, 32'h0, 32'h0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk_inst("wait_redir_b", 1'b0, 32'h0, 32'h0);
    chk_req("wait_redir", 1'b1, 32'h8000_0100);

    // Redirect and inst_ready together in S_OUT: redirect wins.
    fetch(32'h1234_5678);
    chk_inst("out_redir", 1'b1, 32'h1234_5678, 32'h8000_0100);
    bus.inst_ready    = 1'b1;
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 32'h8000_0040;
    tick();
    bus.inst_ready    = 1'b0;
    bus.redirect_en   = 1'b0;
    chk_inst("out_redir_next", 1'b0, 32'h0, 32'h0);
    chk_req("out_redir_next", 1'b1, 32'h8000_0040);

    // Redirect in S_REQ without handshake: old request completes, response dropped.
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 32'h8000_0200;
    tick();
    bus.redirect_en   = 1'b0;
    chk_req("req_redir_hold", 1'b1, 32'h8000_0040);
    fetch(32'hBAD0_0001);
    chk_inst("req_redir_drop", 1'b0, 32'h0, 32'h0);
    chk_req("req_redir_drop", 1'b1, 32'h8000_0200);

    // Redirect with handshake in the same cycle, to the top word (alignment + wrap).
    bus.imem_req_ready = 1'b1;
    bus.redirect_en    = 1'b1;
    bus.redirect_addr  = 32'hFFFF_FFFF;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_en    = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_0002;
    tick();
    bus.imem_rsp_valid = 1'b0;
    chk_inst("hs_redir_drop", 1'b0, 32'h0, 32'h0);
    chk_req("hs_redir_drop", 1'b1, 32'hFFFF_FFFC);
    fetch(32'h0000_0013);
    chk_inst("wrap_out", 1'b1, 32'h0000_0013, 32'hFFFF_FFFC);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk_req("wrap_next", 1'b1, 32'h0000_0000);

    // Reset in the middle of a transaction abandons it.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("midrst_req_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("midrst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk_req("midrst_first", 1'b1, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
